dec_tdm_scheduler: RTL

Time-division output scheduler that shares one serial output line and frame-sync strobe between up to N_CH decimator channels. Each channel delivers a parallel DATA_W-bit sample with a one-cycle valid pulse once per decimation period. The block buffers one sample per channel and arbitrates round-robin. It shifts the granted word out MSB-first with a frame-sync on the first bit, and presents the channel index alongside. It sits between the per-channel decimator cores and the chip's serial output pad, feeding the existing 22-bit deserializer.

---
 rtl/dec_tdm_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dec_tdm_scheduler.sv
// Round-robin TDM serializer for decimator channels.
// One sample buffered per channel, shifted out MSB-first with frame sync.
module dec_tdm_scheduler #(
  parameter int DATA_W = 22,
  parameter int N_CH   = 4,
  parameter int CH_W   = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   sample_i,
  input  logic [N_CH-1:0]          valid_i,
  input  logic [N_CH-1:0]          ch_en_i,
  input  logic                     ovr_clr_i,
  output logic                     data_o,
  output logic                     frame_sync_o,
  output logic [CH_W-1:0]          slot_o,
  output logic                     busy_o,
  output logic [N_CH-1:0]          overrun_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CH_W:0] NCH = (CH_W+1)'(N_CH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] hold [N_CH];
  logic [N_CH-1:0]   pend, pend_nxt;
  logic [N_CH-1:0]   ovr, ovr_nxt, ovr_set;
  logic [N_CH-1:0]   cap, take;
  logic [CH_W-1:0]   rr_ptr, grant, slot;
  logic [CH_W:0]     idx;
  logic              grant_vld, fire, last_bit;
  logic [DATA_W-1:0] shifter;
  logic [CNT_W-1:0]  cnt;

  // Rotating priority search starting at rr_ptr
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (idx >= NCH) idx = idx - NCH;
      if (!grant_vld && pend[idx[CH_W-1:0]]) begin
        grant     = idx[CH_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  assign fire     = (state == IDLE) && grant_vld;
  assign last_bit = (cnt == CNT_W'(DATA_W-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (grant_vld) state_nxt = SHIFT;
      SHIFT: if (last_bit)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state == SHIFT);
    data_o       = busy_o & shifter[DATA_W-1];
    frame_sync_o = busy_o && (cnt == '0);
    slot_o       = slot;
    overrun_o    = ovr;
  end

  // A grant and a capture in the same cycle is not an overrun:
  // the shifter takes the old word, the new one stays pending.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      cap[k]     = valid_i[k] && ch_en_i[k];
      take[k]    = fire && (grant == CH_W'(k));
      ovr_set[k] = cap[k] && pend[k] && !take[k];
      if (!ch_en_i[k])  pend_nxt[k] = 1'b0;
      else if (cap[k])  pend_nxt[k] = 1'b1;
      else if (take[k]) pend_nxt[k] = 1'b0;
      else              pend_nxt[k] = pend[k];
    end
    ovr_nxt = (ovr_clr_i ? '0 : ovr) | ovr_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) hold[k] <= '0;
      pend <= '0;
      ovr  <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++)
        if (cap[k]) hold[k] <= sample_i[k*DATA_W +: DATA_W];
      pend <= pend_nxt;
      ovr  <= ovr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shifter <= '0;
      cnt     <= '0;
      slot    <= '0;
      rr_ptr  <= '0;
    end else if (fire) begin
      shifter <= hold[grant];
      cnt     <= '0;
      slot    <= grant;
      rr_ptr  <= (grant == CH_W'(N_CH-1)) ? '0 : grant + 1'b1;
    end else if (state == SHIFT) begin
      shifter <= {shifter[DATA_W-2:0], 1'b0};
      cnt     <= cnt + 1'b1;
    end
  end

endmodule
